// File: rtl/prim_ram_1p_scrub.sv
// Init/scrub sweep engine on the request side of a single-port ECC RAM wrapper.
// Optional feature macro: PRIM_RAM_SCRUB_WRITEBACK_EN (write corrected data back on correctable errors).
module prim_ram_1p_scrub #(
  parameter int  Depth    = 512,
  parameter int  Width    = 32,
  parameter int  CntWidth = 16,
  localparam int Aw       = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                init_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                ram_req_o,
  input  logic                ram_gnt_i,
  output logic                ram_write_o,
  output logic [Aw-1:0]       ram_addr_o,
  output logic [Width-1:0]    ram_wdata_o,
  output logic [Width-1:0]    ram_wmask_o,
  input  logic                ram_rvalid_i,
  input  logic [Width-1:0]    ram_rdata_i,
  input  logic [1:0]          ram_rerror_i,
  output logic [CntWidth-1:0] corr_cnt_o,
  output logic [CntWidth-1:0] uncorr_cnt_o,
  output logic [Aw-1:0]       last_uncorr_addr_o
);

  // state | meaning: IDLE wait start, INIT zero-fill, RD read request, WAIT read response,
  // WB corrected-data write, DONE one-cycle end pulse
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StInit = 3'd1;
  localparam logic [2:0] StRd   = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StDone = 3'd5;
`ifdef PRIM_RAM_SCRUB_WRITEBACK_EN
  localparam logic [2:0] StWb   = 3'd4;
`endif

  localparam logic [Aw-1:0]       LastAddr = Aw'(Depth - 1);
  localparam logic [CntWidth-1:0] CntMax   = '1;

  logic [2:0]          state_q, state_d;
  logic [Aw-1:0]       addr_q, addr_d;
  logic                busy_q, busy_d;
  logic [CntWidth-1:0] corr_q, corr_d;
  logic [CntWidth-1:0] uncorr_q, uncorr_d;
  logic [Aw-1:0]       last_q, last_d;
  logic                advance;
  logic                is_wb;

`ifdef PRIM_RAM_SCRUB_WRITEBACK_EN
  logic [Width-1:0]    wb_data_q, wb_data_d;
  assign is_wb       = (state_q == StWb);
  assign ram_wdata_o = is_wb ? wb_data_q : '0;
`else
  logic                unused_rdata;
  assign unused_rdata = ^ram_rdata_i;
  assign is_wb        = 1'b0;
  assign ram_wdata_o  = '0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    last_d   = last_q;
    advance  = 1'b0;
`ifdef PRIM_RAM_SCRUB_WRITEBACK_EN
    wb_data_d = wb_data_q;
`endif
    case (state_q)
      StIdle: begin
        if (start_i) begin
          corr_d   = '0;
          uncorr_d = '0;
          last_d   = '0;
          addr_d   = '0;
          busy_d   = 1'b1;
          state_d  = init_i ? StInit : StRd;
        end
      end
      StInit: begin
        if (ram_gnt_i) advance = 1'b1;
      end
      StRd: begin
        if (ram_gnt_i) state_d = StWait;
      end
      StWait: begin
        if (ram_rvalid_i) begin
          if (ram_rerror_i[1]) begin
            if (uncorr_q != CntMax) uncorr_d = uncorr_q + CntWidth'(1);
            last_d  = addr_q;
            advance = 1'b1;
          end else if (ram_rerror_i[0]) begin
            if (corr_q != CntMax) corr_d = corr_q + CntWidth'(1);
`ifdef PRIM_RAM_SCRUB_WRITEBACK_EN
            wb_data_d = ram_rdata_i;
            state_d   = StWb;
`else
            advance   = 1'b1;
`endif
          end else begin
            advance = 1'b1;
          end
        end
      end
`ifdef PRIM_RAM_SCRUB_WRITEBACK_EN
      StWb: begin
        if (ram_gnt_i) advance = 1'b1;
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Address never wraps: the last word ends the sweep instead of incrementing.
    if (advance) begin
      if (addr_q == LastAddr) begin
        state_d = StDone;
        busy_d  = 1'b0;
      end else begin
        addr_d  = addr_q + Aw'(1);
        state_d = (state_q == StInit) ? StInit : StRd;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      corr_q   <= '0;
      uncorr_q <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      last_q   <= last_d;
    end
  end

`ifdef PRIM_RAM_SCRUB_WRITEBACK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_data_q <= '0;
    end else begin
      wb_data_q <= wb_data_d;
    end
  end
`endif

  assign ram_req_o          = (state_q == StInit) || (state_q == StRd) || is_wb;
  assign ram_write_o        = (state_q == StInit) || is_wb;
  assign ram_addr_o         = addr_q;
  assign ram_wmask_o        = {Width{ram_req_o}};
  assign busy_o             = busy_q;
  assign done_o             = (state_q == StDone);
  assign corr_cnt_o         = corr_q;
  assign uncorr_cnt_o       = uncorr_q;
  assign last_uncorr_addr_o = last_q;

endmodule

// File: tb/tb_prim_ram_1p_scrub.sv
// Randomized self-checking bench for prim_ram_1p_scrub against a word-level sweep model.
module tb_prim_ram_1p_scrub;
  localparam int Depth     = 8;
  localparam int Width     = 32;
  localparam int CntWidth  = 16;
  localparam int Aw        = 3;
  localparam int Depth2    = 6;
  localparam int CntWidth2 = 2;
  localparam int Aw2       = 3;
`ifdef PRIM_RAM_SCRUB_WRITEBACK_EN
  localparam bit WbEn = 1'b1;
`else
  localparam bit WbEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, init, busy, done, req, gnt, write, rvalid;
  logic [Aw-1:0]       addr, last;
  logic [Width-1:0]    wdata, wmask, rdata;
  logic [1:0]          rerror;
  logic [CntWidth-1:0] corr, uncorr;

  logic start2, init2, busy2, done2, req2, write2;
  logic gnt2 = 1'b1, rvalid2 = 1'b1;
  logic [Aw2-1:0]       addr2, last2;
  logic [Width-1:0]     wdata2, wmask2;
  logic [Width-1:0]     rdata2 = 32'h5A5A_0000;
  logic [1:0]           rerror2;
  logic [CntWidth2-1:0] corr2, uncorr2;

  always #5 clk = ~clk;

  prim_ram_1p_scrub #(.Depth(Depth), .Width(Width), .CntWidth(CntWidth)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .init_i(init), .busy_o(busy), .done_o(done),
    .ram_req_o(req), .ram_gnt_i(gnt), .ram_write_o(write), .ram_addr_o(addr),
    .ram_wdata_o(wdata), .ram_wmask_o(wmask), .ram_rvalid_i(rvalid), .ram_rdata_i(rdata),
    .ram_rerror_i(rerror), .corr_cnt_o(corr), .uncorr_cnt_o(uncorr), .last_uncorr_addr_o(last)
  );

  prim_ram_1p_scrub #(.Depth(Depth2), .Width(Width), .CntWidth(CntWidth2)) u_dut_d6 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .init_i(init2), .busy_o(busy2), .done_o(done2),
    .ram_req_o(req2), .ram_gnt_i(gnt2), .ram_write_o(write2), .ram_addr_o(addr2),
    .ram_wdata_o(wdata2), .ram_wmask_o(wmask2), .ram_rvalid_i(rvalid2), .ram_rdata_i(rdata2),
    .ram_rerror_i(rerror2), .corr_cnt_o(corr2), .uncorr_cnt_o(uncorr2), .last_uncorr_addr_o(last2)
  );

  typedef struct packed {
    logic             wr;
    logic [Aw-1:0]    addr;
    logic [Width-1:0] wdata;
  } txn_t;

  logic [1:0]       err_mem [Depth];
  logic [Width-1:0] dat_mem [Depth];
  txn_t             exp_q[$];
  int exp_corr, exp_uncorr, exp_last;
  int checks = 0, failures = 0;
  int cyc = 0, lat = 1, gnt_mode = 0, acc_idx = 0, resp_wait = 0;
  bit spurious = 1'b0, in_sweep = 1'b0, resp_pend = 1'b0;
  logic [Aw-1:0] resp_addr, acc_addr;
  bit acc_v, acc_wr;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected transaction list and counters of one full sweep, word by word.
  task automatic build_model(input bit mode);
    txn_t t;
    exp_q.delete();
    exp_corr = 0; exp_uncorr = 0; exp_last = 0;
    for (int a = 0; a < Depth; a++) begin
      t.wr = mode; t.addr = Aw'(a); t.wdata = '0;
      exp_q.push_back(t);
      if (!mode) begin
        if (err_mem[a][1]) begin
          exp_uncorr++; exp_last = a;
        end else if (err_mem[a][0]) begin
          exp_corr++;
          if (WbEn) begin t.wr = 1'b1; t.wdata = dat_mem[a]; exp_q.push_back(t); end
        end
      end
    end
  endtask

  task automatic randomize_mem();
    for (int a = 0; a < Depth; a++) begin
      case ($urandom_range(0, 7))
        0: err_mem[a] = 2'b01;
        1: err_mem[a] = 2'b10;
        2: err_mem[a] = 2'b11;
        default: err_mem[a] = 2'b00;
      endcase
      dat_mem[a] = $urandom;
    end
  endtask

  // One clock cycle: drive grant/response at the falling edge, then observe the bus.
  task automatic step();
    logic [Width-1:0] wd;
    @(negedge clk);
    cyc++;
    case (gnt_mode)
      0: gnt = 1'b1;
      1: gnt = ((cyc % 2) != 0);
      default: gnt = ($urandom_range(0, 2) != 0);
    endcase
    rvalid = 1'b0; rdata = $urandom; rerror = 2'($urandom);
    if (resp_pend) begin
      if (resp_wait == 0) begin
        rvalid = 1'b1; rdata = dat_mem[resp_addr]; rerror = err_mem[resp_addr]; resp_pend = 1'b0;
      end else begin
        resp_wait--;
      end
    end else if (spurious) begin
      rvalid = ($urandom_range(0, 3) == 0);
    end
    acc_v = req & gnt; acc_wr = write; acc_addr = addr;
    if (in_sweep && req) begin
      wd = write ? wdata : '0;
      if (acc_idx < exp_q.size()) begin
        check_eq("req_bus", {write, addr, wd}, exp_q[acc_idx]);
        check_eq("wmask", wmask, {Width{1'b1}});
      end else begin
        check_eq("extra_txn", acc_idx, exp_q.size() - 1);
      end
      if (gnt) acc_idx++;
    end
    if (acc_v && !write) begin
      resp_pend = 1'b1; resp_wait = lat - 1; resp_addr = addr;
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ctl"}, {req, write, busy, done}, 4'b0000);
    check_eq({tag, "_addr"}, addr, 0);
    check_eq({tag, "_wdata"}, wdata, 0);
    check_eq({tag, "_wmask"}, wmask, 0);
    check_eq({tag, "_cnt"}, {corr, uncorr, last}, 0);
  endtask

  task automatic run_sweep(input bit mode, input bit timed, input string tag);
    int n, exp_n;
    bit got_done;
    build_model(mode);
    exp_n = 1 + (mode ? Depth : Depth * (1 + lat) + (exp_q.size() - Depth));
    acc_idx = 0; in_sweep = 1'b1;
    start = 1'b1; init = mode;
    step(); n = 1;
    check_eq({tag, "_busy_rise"}, busy, 1'b1);
    check_eq({tag, "_first_req"}, req, 1'b1);
    got_done = done;
    while (!got_done && n < 4000) begin
      start = ($urandom_range(0, 7) == 0); init = 1'($urandom_range(0, 1));
      step(); n++;
      got_done = done;
    end
    check_eq({tag, "_done_seen"}, got_done, 1'b1);
    check_eq({tag, "_busy_at_done"}, busy, 1'b0);
    if (timed) check_eq({tag, "_done_cycle"}, n, exp_n);
    in_sweep = 1'b0;
    start = 1'b1; init = 1'($urandom_range(0, 1));
    step();
    start = 1'b0;
    check_eq({tag, "_idle_after"}, {done, busy, req}, 3'b000);
    check_eq({tag, "_txn_count"}, acc_idx, exp_q.size());
    check_eq({tag, "_corr"}, corr, exp_corr);
    check_eq({tag, "_uncorr"}, uncorr, exp_uncorr);
    check_eq({tag, "_last_uncorr"}, last, exp_last);
  endtask

  // Depth=6, narrow counters: every word returns the same error code, grant and rvalid held high.
  task automatic run2(input bit mode, input logic [1:0] rerr, input string tag);
    int n, nacc, exp_n, exp_acc, exp_c, exp_u, exp_l, sat;
    logic [Depth2-1:0] seen;
    bit bad, got_done, wb;
    sat     = (1 << CntWidth2) - 1;
    wb      = WbEn && !mode && (rerr == 2'b01);
    exp_acc = Depth2 * (wb ? 2 : 1);
    exp_n   = 1 + (mode ? Depth2 : Depth2 * (wb ? 3 : 2));
    exp_c   = (!mode && rerr == 2'b01) ? ((Depth2 < sat) ? Depth2 : sat) : 0;
    exp_u   = (!mode && rerr[1]) ? ((Depth2 < sat) ? Depth2 : sat) : 0;
    exp_l   = (!mode && rerr[1]) ? Depth2 - 1 : 0;
    rerror2 = rerr;
    start2 = 1'b1; init2 = mode;
    @(negedge clk);
    start2 = 1'b0; n = 1;
    nacc = 0; seen = '0; bad = 1'b0; got_done = 1'b0;
    while (n < 500) begin
      if (req2) begin
        nacc++;
        check_eq({tag, "_wmask"}, wmask2, {Width{1'b1}});
        if (addr2 >= Aw2'(Depth2)) bad = 1'b1;
        else if (write2 == mode) begin
          if (seen[addr2]) bad = 1'b1;
          seen[addr2] = 1'b1;
        end
        if (write2) check_eq({tag, "_wdata"}, wdata2, mode ? '0 : rdata2);
      end
      if (done2) begin got_done = 1'b1; break; end
      @(negedge clk); n++;
    end
    check_eq({tag, "_done_seen"}, got_done, 1'b1);
    check_eq({tag, "_done_cycle"}, n, exp_n);
    check_eq({tag, "_busy_at_done"}, busy2, 1'b0);
    check_eq({tag, "_txn_count"}, nacc, exp_acc);
    check_eq({tag, "_addr_cover"}, seen, {Depth2{1'b1}});
    check_eq({tag, "_addr_range_dup"}, bad, 1'b0);
    check_eq({tag, "_corr"}, corr2, exp_c);
    check_eq({tag, "_uncorr"}, uncorr2, exp_u);
    check_eq({tag, "_last_uncorr"}, last2, exp_l);
    @(negedge clk);
    check_eq({tag, "_idle_after"}, {done2, req2}, 2'b00);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; init = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; rerror = '0;
    start2 = 1'b0; init2 = 1'b0; rerror2 = '0;
    for (int a = 0; a < Depth; a++) begin err_mem[a] = 2'b00; dat_mem[a] = $urandom; end
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();

    gnt_mode = 0; lat = 1;
    run_sweep(1'b1, 1'b1, "init_g1");
    run_sweep(1'b0, 1'b1, "scrub_clean");
    err_mem[3] = 2'b01; dat_mem[3] = 32'hA5A5_0003;
    run_sweep(1'b0, 1'b1, "scrub_corr3");
    err_mem[3] = 2'b00; err_mem[5] = 2'b11; lat = 2;
    run_sweep(1'b0, 1'b1, "scrub_uncorr5");
    err_mem[5] = 2'b00;

    gnt_mode = 1; lat = 1;
    run_sweep(1'b1, 1'b0, "init_toggle");
    randomize_mem();
    run_sweep(1'b0, 1'b0, "scrub_toggle");

    gnt_mode = 2; spurious = 1'b1;
    for (int t = 0; t < 8; t++) begin
      randomize_mem();
      lat = $urandom_range(1, 4);
      run_sweep($urandom_range(0, 3) == 0, 1'b0, "rnd");
    end
    gnt_mode = 0; lat = 3;
    randomize_mem();
    run_sweep(1'b0, 1'b1, "scrub_l3_timed");

    spurious = 1'b0;
    for (int a = 0; a < Depth; a++) err_mem[a] = 2'b00;
    err_mem[4] = 2'b11;
    build_model(1'b0); acc_idx = 0; in_sweep = 1'b1;
    start = 1'b1; init = 1'b0;
    step();
    start = 1'b0; n = 0;
    while (!(acc_v && !acc_wr && acc_addr == 3'd4) && n < 200) begin step(); n++; end
    check_eq("rst_reach_addr4", {acc_v, acc_wr, acc_addr}, {1'b1, 1'b0, 3'd4});
    rst = 1'b1; in_sweep = 1'b0;
    step();
    check_zero("rst_mid");
    rst = 1'b0;
    repeat (5) step();
    check_eq("rst_late_rvalid", {uncorr, corr, busy, req}, 0);
    run_sweep(1'b0, 1'b1, "scrub_after_rst");

    run2(1'b1, 2'b00, "d6_init");
    run2(1'b0, 2'b01, "d6_corr_sat");
    run2(1'b0, 2'b11, "d6_uncorr_sat");
    run2(1'b0, 2'b00, "d6_clean");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
